// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback stage with 2-cycle multiply writeback.
// Contents: FSM state encoding, register-number constants, default widths.
package pipeline_pkg;

    // Default datapath widths
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Architectural register numbers with special handling
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_LAST = 31;

    // Writeback FSM states
    localparam logic [0:0] S_LO = 1'b0;   // normal writeback
    localparam logic [0:0] S_HI = 1'b1;   // high-half write of a multiply

endpackage : pipeline_pkg

// File: rtl/wb_result_mux.sv
// Writeback result selection: load data or the low half of the ALU/multiplier result.
// Ports:
//   mem_2_reg   - 1 selects memreg, 0 selects aluout_lo
//   aluout_lo   - low DATA_W bits of the ALU/multiplier result
//   memreg      - load data
//   result_c    - selected write data (combinational)
module wb_result_mux
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              mem_2_reg,
    input  logic [DATA_W-1:0] aluout_lo,
    input  logic [DATA_W-1:0] memreg,
    output logic [DATA_W-1:0] result_c
);

    always_comb begin
        result_c = mem_2_reg ? memreg : aluout_lo;
    end

endmodule : wb_result_mux

// File: rtl/wb_stage_mult2.sv
// Writeback stage downstream of MEM/WB. Drives the register-file write port and
// splits a 2*DATA_W multiply product into two consecutive writes (rd, rd+1),
// stalling MEM/WB for the cycle in which the high half is written.
// Optional build macro: WB_PERF_CNT_EN adds retired/stall performance counters.
// Ports:
//   clk, rst      - pipeline clock, synchronous active-high reset
//   in_valid      - MEM/WB holds a live instruction
//   reg_write     - instruction writes a register
//   mem_2_reg     - 1 selects memreg, 0 selects aluout
//   is_mult       - aluout holds a full 2*DATA_W product
//   aluout        - ALU/multiplier result
//   memreg        - load data
//   rd            - destination register
//   stall_o       - holds MEM/WB (MEM/WB enable is ~stall_o)
//   rf_we/rf_waddr/rf_wdata - registered register-file write port
//   retire_o      - one-cycle pulse when an instruction's last write issues
//   retired_cnt, stall_cnt - (WB_PERF_CNT_EN only) wrapping event counters
module wb_stage_mult2
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  reg_write,
    input  logic                  mem_2_reg,
    input  logic                  is_mult,
    input  logic [2*DATA_W-1:0]   aluout,
    input  logic [DATA_W-1:0]     memreg,
    input  logic [ADDR_W-1:0]     rd,
    output logic                  stall_o,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  retire_o
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]           retired_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(REG_LAST);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [DATA_W-1:0] hi_data;
    logic [DATA_W-1:0] hi_data_nxt;
    logic [ADDR_W-1:0] hi_addr;
    logic [ADDR_W-1:0] hi_addr_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              retire_nxt;
    logic [DATA_W-1:0] result_c;
    logic              do_write_c;
    logic              split_c;

    // Low-half / load data selection
    wb_result_mux #(
        .DATA_W (DATA_W)
    ) u_result_mux (
        .mem_2_reg (mem_2_reg),
        .aluout_lo (aluout[DATA_W-1:0]),
        .memreg    (memreg),
        .result_c  (result_c)
    );

    // Stall is a pure decode of the state register
    assign stall_o = (state == S_HI);

    // A write is taken only for a live register-writing instruction; rd=31 never
    // splits so the high half cannot wrap around to x0
    assign do_write_c = in_valid && reg_write;
    assign split_c    = do_write_c && is_mult && !mem_2_reg && (rd != RD_LAST);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LO;
            hi_data  <= '0;
            hi_addr  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retire_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            hi_data  <= hi_data_nxt;
            hi_addr  <= hi_addr_nxt;
            rf_we    <= we_nxt;
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
            retire_o <= retire_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        hi_data_nxt = hi_data;
        hi_addr_nxt = hi_addr;
        we_nxt      = 1'b0;
        waddr_nxt   = rf_waddr;
        wdata_nxt   = rf_wdata;
        retire_nxt  = 1'b0;

        case (state)
            S_LO: begin
                if (do_write_c) begin
                    waddr_nxt = rd;
                    wdata_nxt = result_c;
                    we_nxt    = (rd != RD_ZERO);
                    if (split_c) begin
                        hi_data_nxt = aluout[2*DATA_W-1:DATA_W];
                        hi_addr_nxt = rd + ADDR_W'(1);
                        state_nxt   = S_HI;
                        retire_nxt  = 1'b0;
                    end else begin
                        retire_nxt  = 1'b1;
                    end
                end else begin
                    retire_nxt = in_valid;
                end
            end
            S_HI: begin
                // MEM/WB was held, so current inputs are revisited next edge
                we_nxt     = 1'b1;
                waddr_nxt  = hi_addr;
                wdata_nxt  = hi_data;
                retire_nxt = 1'b1;
                state_nxt  = S_LO;
            end
            default: begin
                state_nxt = S_LO;
            end
        endcase
    end

`ifdef WB_PERF_CNT_EN
    // Wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            retired_cnt <= retired_cnt + 32'(retire_o);
            stall_cnt   <= stall_cnt + 32'(stall_o);
        end
    end
`endif

endmodule : wb_stage_mult2

// File: doc/wb_stage_mult2.md
Name: wb_stage_mult2

Overview:
- Writeback stage directly downstream of the MEM/WB pipeline register in the basic 5-stage pipeline with 2-cycle multiply writeback.
- Selects the result (ALU or memory), drives the register-file write port, and splits 64-bit multiply results into two consecutive register writes (rd, rd+1).
- While the high half is being written, it stalls the MEM/WB register through stall_o.

Parameters:
- DATA_W, 32, register-file data width; the multiply result is 2*DATA_W.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  pipeline clock (rising edge)
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM/WB holds a live instruction
- reg_write  in  1  instruction writes a register
- mem_2_reg  in  1  1 selects memreg, 0 selects aluout
- is_mult  in  1  aluout holds a full 2*DATA_W product
- aluout  in  2*DATA_W  ALU/multiplier result
- memreg  in  DATA_W  load data
- rd  in  ADDR_W  destination register
- stall_o  out  1  holds MEM/WB; the MEM/WB enable is ~stall_o
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)
- retire_o  out  1  one-cycle pulse when an instruction's last write issues

Behaviour:
- Reset:
  - One clock is the only clock; reset is synchronous and active-high.
  - Ports are named clk and rst.
  - While rst=1 at a rising edge: state=S_LO, rf_we=0, rf_waddr=0, rf_wdata=0, retire_o=0, hi buffer=0.
  - stall_o=0 during and after reset.
- States: S_LO (normal), S_HI (high-half write). stall_o=1 iff state==S_HI (decoded from state only).
- S_LO, edge with in_valid && reg_write:
  - rf_waddr=rd.
  - rf_wdata = mem_2_reg ? memreg : aluout[DATA_W-1:0].
  - rf_we = (rd!=0).
- S_LO, split condition: if is_mult && !mem_2_reg && rd!=31:
  - latch hi buffer = aluout[2*DATA_W-1:DATA_W] and the target rd+1;
  - next state S_HI; retire_o=0.
  - Otherwise retire_o=1 and state stays S_LO.
- S_LO, edge without in_valid && reg_write: rf_we=0, retire_o=in_valid, state stays S_LO.
- S_HI, next edge:
  - rf_we=1, rf_waddr=rd+1, rf_wdata=hi buffer, retire_o=1, next state S_LO.
  - Inputs are ignored on this edge. MEM/WB did not load, so it still holds the next instruction, which is sampled on the following edge.
- Latency:
  - Input to rf_we is 1 cycle.
  - A multiply occupies 2 write cycles and 1 stall cycle.
  - Throughput is 1 instruction/cycle otherwise.
- Boundaries:
  - rd=0 multiply: the low write is suppressed (rf_we=0), the high half is written to x1, and the stall still occurs.
  - rd=31 multiply: no wrap. Only the low half is written, with no stall and retire_o=1.
  - is_mult with mem_2_reg=1: treated as a plain load, no split.
  - Reset while in S_HI: the pending high write is dropped, state returns to S_LO, and stall_o releases in the cycle after reset.
- Back-to-back multiplies: each one gets its own S_HI cycle. The stall pattern is 0,1,0,1.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0], both cleared by rst.
  - retired_cnt increments on each retire_o pulse.
  - stall_cnt increments each cycle stall_o=1.
  - Both wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package (pipeline_pkg):
  - state encoding S_LO=1'b0, S_HI=1'b1;
  - constants REG_ZERO=0, REG_LAST=31;
  - defaults for DATA_W and ADDR_W.
- One natural sub-module: wb_result_mux, combinational selection of memreg or the aluout low half. The FSM, hi buffer and output registers stay in the top module.

Test Plan:
- Reset then idle (in_valid=0 for 5 cycles) -> rf_we=0, stall_o=0, retire_o=0 throughout.
- ALU op rd=5, aluout=0x0000_0000_1234_5678 -> one cycle later rf_we=1, waddr=5, wdata=0x12345678, retire_o=1, no stall.
- Load rd=7, mem_2_reg=1, memreg=0xDEADBEEF, is_mult=1 -> single write of 0xDEADBEEF to x7, no stall.
- Multiply rd=10, aluout=0xAAAA_BBBB_CCCC_DDDD, next instruction an ALU op rd=3:
  - Cycle 1: write x10=0xCCCCDDDD.
  - Cycle 2: stall_o=1, then write x11=0xAAAABBBB.
  - Cycle 3: write x3. retire_o pulses twice in total.
- Multiply rd=31 -> only x31 is written with the low half, stall_o never asserts. Multiply rd=0 -> rf_we=0 in the first cycle, then x1 is written with the high half.
- Multiply rd=4 with rst=1 asserted during S_HI -> x5 is never written, stall_o=0 after reset, and the next ALU op writes normally.
